// File: rtl/deleted_node_cam_if.sv
// Insert, lookup and status bundle for the deleted-node CAM.
// The master drives requests; the slave (the CAM) returns results and status.
interface deleted_node_cam_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_DELETIONS = 16,
  parameter int NUM_QUERY     = 2
);
  localparam int CNT_W = $clog2(MAX_DELETIONS + 1);

  logic                            clr;
  logic                            ins_valid;
  logic                            ins_ready;
  logic                            ins_conn;
  logic [DATA_WIDTH-1:0]           ins_node;
  logic                            q_valid;
  logic [NUM_QUERY*DATA_WIDTH-1:0] q_node;
  logic                            q_match_valid;
  logic [NUM_QUERY-1:0]            q_match;
  logic                            match_any;
  logic [CNT_W-1:0]                count;
  logic                            full;
  logic                            empty;
  logic                            overflow;

  modport master (
    output clr, ins_valid, ins_conn, ins_node, q_valid, q_node,
    input  ins_ready, q_match_valid, q_match, match_any, count, full, empty, overflow
  );

  modport slave (
    input  clr, ins_valid, ins_conn, ins_node, q_valid, q_node,
    output ins_ready, q_match_valid, q_match, match_any, count, full, empty, overflow
  );
endinterface

// File: rtl/deleted_node_cam.sv
// Content-addressable store of deleted node IDs: NUM_QUERY lookups plus one insert per cycle.
// Entries fill in order and are only emptied by a bulk clear or reset.
module deleted_node_cam #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_DELETIONS = 16,
  parameter int NUM_QUERY     = 2
) (
  input logic                 clk,
  input logic                 rst,
  deleted_node_cam_if.slave   bus
);
  localparam int CNT_W = $clog2(MAX_DELETIONS + 1);

  logic [MAX_DELETIONS-1:0] valid;
  logic [DATA_WIDTH-1:0]    data [MAX_DELETIONS];
  logic [CNT_W-1:0]         count;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic                     q_match_valid;
  logic [NUM_QUERY-1:0]     q_match;

  logic                     ins_hit;
  logic [NUM_QUERY-1:0]     q_hit;
  logic                     ins_fire;
  logic                     ins_write;
  logic [CNT_W-1:0]         count_next;

  always_comb begin
    ins_hit = 1'b0;
    for (int i = 0; i < MAX_DELETIONS; i++)
      if (valid[i] && (data[i] == bus.ins_node)) ins_hit = 1'b1;
  end

  always_comb begin
    q_hit = '0;
    for (int k = 0; k < NUM_QUERY; k++)
      for (int i = 0; i < MAX_DELETIONS; i++)
        if (valid[i] && (data[i] == bus.q_node[k*DATA_WIDTH +: DATA_WIDTH])) q_hit[k] = 1'b1;
  end

  assign bus.ins_ready = !full && !bus.clr && !rst;
  assign ins_fire      = bus.ins_valid && bus.ins_ready;
  assign ins_write     = ins_fire && !bus.ins_conn && !ins_hit;
  assign count_next    = count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid         <= '0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      overflow      <= 1'b0;
      q_match_valid <= 1'b0;
      q_match       <= '0;
    end else begin
      // lookups use pre-update contents and are not cancelled by clr
      q_match_valid <= bus.q_valid;
      if (bus.q_valid) q_match <= q_hit;

      if (bus.clr) begin
        valid    <= '0;
        count    <= '0;
        full     <= 1'b0;
        empty    <= 1'b1;
        overflow <= 1'b0;
      end else begin
        if (ins_write) begin
          for (int i = 0; i < MAX_DELETIONS; i++)
            if (CNT_W'(i) == count) valid[i] <= 1'b1;
          count <= count_next;
          full  <= (count_next == CNT_W'(MAX_DELETIONS));
          empty <= 1'b0;
        end
        if (bus.ins_valid && !bus.ins_conn && full && !ins_hit) overflow <= 1'b1;
      end
    end
  end

  // entry payload needs no reset; a match always requires the valid bit
  always_ff @(posedge clk) begin
    if (ins_write)
      for (int i = 0; i < MAX_DELETIONS; i++)
        if (CNT_W'(i) == count) data[i] <= bus.ins_node;
  end

  assign bus.count         = count;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.overflow      = overflow;
  assign bus.q_match_valid = q_match_valid;
  assign bus.q_match       = q_match;
  assign bus.match_any     = q_match_valid && (|q_match);
endmodule

// File: tb/tb_deleted_node_cam.sv
// Directed self-checking bench for deleted_node_cam with hand-computed expectations.
module tb_deleted_node_cam;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  deleted_node_cam_if #(.DATA_WIDTH(8), .MAX_DELETIONS(16), .NUM_QUERY(2)) bus ();

  deleted_node_cam #(.DATA_WIDTH(8), .MAX_DELETIONS(16), .NUM_QUERY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.clr = 1'b0; bus.ins_valid = 1'b0; bus.ins_conn = 1'b0;
    bus.ins_node = '0; bus.q_valid = 1'b0; bus.q_node = '0;
    step(); step();
    checks++; if (bus.ins_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %0h expected 0", bus.ins_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %0b%0b expected 10", bus.empty, bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0h expected 0", bus.overflow); end
    checks++; if (bus.q_match_valid !== 1'b0 || bus.q_match !== 2'b00) begin errors++; $display("FAIL reset_qmatch: got %0b/%0b expected 0/00", bus.q_match_valid, bus.q_match); end
    checks++; if (bus.ins_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h expected 1", bus.ins_ready); end
    bus.q_valid = 1'b1; bus.q_node = {8'hFF, 8'h05};
    step();
    bus.q_valid = 1'b0;
    checks++; if (bus.q_match_valid !== 1'b1 || bus.q_match !== 2'b00) begin errors++; $display("FAIL empty_lookup: got %0b/%0b expected 1/00", bus.q_match_valid, bus.q_match); end
    checks++; if (bus.match_any !== 1'b0) begin errors++; $display("FAIL empty_match_any: got %0h expected 0", bus.match_any); end
  endtask

  task automatic test_insert_dup();
    bus.ins_valid = 1'b1; bus.ins_node = 8'h12;
    step();
    checks++; if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin errors++; $display("FAIL first_insert: got count %0d empty %0b expected 1 0", bus.count, bus.empty); end
    bus.ins_node = 8'h34; step();
    bus.ins_node = 8'h12; step();
    bus.ins_valid = 1'b0;
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL dup_count: got %0d expected 2", bus.count); end
    bus.q_valid = 1'b1; bus.q_node = {8'h34, 8'h12};
    step();
    bus.q_valid = 1'b0;
    checks++; if (bus.q_match !== 2'b11 || bus.match_any !== 1'b1) begin errors++; $display("FAIL lookup_both: got %0b any %0b expected 11 1", bus.q_match, bus.match_any); end
    step();
    checks++; if (bus.q_match_valid !== 1'b0 || bus.q_match !== 2'b11 || bus.match_any !== 1'b0) begin errors++; $display("FAIL lookup_hold: got %0b/%0b/%0b expected 0/11/0", bus.q_match_valid, bus.q_match, bus.match_any); end
  endtask

  task automatic test_conn();
    bus.ins_valid = 1'b1; bus.ins_conn = 1'b1; bus.ins_node = 8'h22;
    step();
    bus.ins_valid = 1'b0; bus.ins_conn = 1'b0;
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL conn_count: got %0d expected 2", bus.count); end
    bus.q_valid = 1'b1; bus.q_node = {8'h12, 8'h22};
    step();
    bus.q_valid = 1'b0;
    checks++; if (bus.q_match !== 2'b10) begin errors++; $display("FAIL conn_lookup: got %0b expected 10", bus.q_match); end
  endtask

  task automatic test_full();
    bus.ins_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.ins_node = 8'h50 + 8'(i);
      step();
    end
    bus.ins_valid = 1'b0;
    checks++; if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.empty !== 1'b0) begin errors++; $display("FAIL fill: got count %0d full %0b empty %0b expected 16 1 0", bus.count, bus.full, bus.empty); end
    checks++; if (bus.ins_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0h expected 0", bus.ins_ready); end
    bus.ins_valid = 1'b1; bus.ins_node = 8'h12;
    step();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL dup_while_full: got overflow %0h expected 0", bus.overflow); end
    bus.ins_node = 8'h99;
    step();
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin errors++; $display("FAIL overflow_set: got %0h count %0d expected 1 16", bus.overflow, bus.count); end
    bus.ins_node = 8'h5D;
    step();
    bus.ins_valid = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %0h expected 1", bus.overflow); end
    bus.q_valid = 1'b1; bus.q_node = {8'h5D, 8'h99};
    step();
    bus.q_valid = 1'b0;
    checks++; if (bus.q_match !== 2'b10) begin errors++; $display("FAIL full_lookup: got %0b expected 10", bus.q_match); end
  endtask

  task automatic test_same_cycle();
    bus.clr = 1'b1;
    #1;
    checks++; if (bus.ins_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %0h expected 0", bus.ins_ready); end
    step();
    bus.clr = 1'b0;
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_state: got count %0d e%0b f%0b o%0b expected 0 1 0 0", bus.count, bus.empty, bus.full, bus.overflow); end
    bus.ins_valid = 1'b1; bus.ins_node = 8'h40;
    bus.q_valid = 1'b1; bus.q_node = {8'h40, 8'h40};
    step();
    bus.ins_valid = 1'b0;
    checks++; if (bus.q_match !== 2'b00 || bus.count !== 5'd1) begin errors++; $display("FAIL same_cycle: got %0b count %0d expected 00 1", bus.q_match, bus.count); end
    step();
    bus.q_valid = 1'b0;
    checks++; if (bus.q_match !== 2'b11) begin errors++; $display("FAIL next_cycle: got %0b expected 11", bus.q_match); end
  endtask

  task automatic test_back_to_back();
    bus.ins_valid = 1'b1;
    bus.ins_node = 8'h41; step();
    bus.ins_node = 8'h42; step();
    bus.ins_valid = 1'b0;
    checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL three_entries: got %0d expected 3", bus.count); end
    bus.clr = 1'b1; bus.ins_valid = 1'b1; bus.ins_node = 8'h77;
    bus.q_valid = 1'b1; bus.q_node = {8'h42, 8'h07};
    step();
    bus.clr = 1'b0; bus.ins_valid = 1'b0;
    checks++; if (bus.q_match_valid !== 1'b1 || bus.q_match !== 2'b10) begin errors++; $display("FAIL clr_lookup: got %0b/%0b expected 1/10", bus.q_match_valid, bus.q_match); end
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL clr_count: got %0d empty %0b expected 0 1", bus.count, bus.empty); end
    step();
    bus.q_valid = 1'b0;
    checks++; if (bus.q_match !== 2'b00) begin errors++; $display("FAIL relookup: got %0b expected 00", bus.q_match); end
  endtask

  initial begin
    test_reset();
    test_insert_dup();
    test_conn();
    test_full();
    test_same_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
